// File: rtl/core_pkg.sv
// Shared core-wide constants: tag and data widths, the null ROB tag and
// functional-unit indices, plus the round-robin pointer helper.
package core_pkg;

    localparam int unsigned ROBEN_W_DEFAULT = 5;
    localparam int unsigned DATA_W_DEFAULT  = 32;

    // ROB tag 0 is reserved to mean "no entry"
    localparam int unsigned ROBEN_NONE = 0;

    localparam int unsigned FU_ALU  = 0;
    localparam int unsigned FU_MUL  = 1;
    localparam int unsigned FU_LDST = 2;
    localparam int unsigned FU_BR   = 3;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
// Shared between the CDB arbiter and the issue-select logic.
module rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] pos;
    int               sum;

    // Walk offsets from farthest to nearest so the nearest requester wins last.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = '0;
        sum   = 0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            sum = int'(ptr) + k;
            pos = IDX_W'(sum % int'(N));
            if (req[pos]) begin
                grant      = '0;
                grant[pos] = 1'b1;
                idx        = pos;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the Common Data Bus: grants one completed result per
// cycle and broadcasts it registered, filtering null tags and squashing on flush.
module cdb_arbiter
    import core_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ROBEN_W = ROBEN_W_DEFAULT,
    parameter int unsigned DATA_W  = DATA_W_DEFAULT,
    localparam int unsigned SRC_W  = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*ROBEN_W-1:0]   req_roben,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       cdb_valid,
    output logic [ROBEN_W-1:0]         cdb_roben,
    output logic [DATA_W-1:0]          cdb_data,
    output logic [SRC_W-1:0]           cdb_src,
    output logic                       err_zero_tag
);

    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]   grant;
    logic [SRC_W-1:0]   grant_idx;
    logic               grant_any;
    logic [ROBEN_W-1:0] sel_roben;
    logic [DATA_W-1:0]  sel_data;
    logic               zero_tag;

    logic               valid_q, valid_d;
    logic [ROBEN_W-1:0] roben_q, roben_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic               err_q, err_d;

    rr_pick #(
        .N (N_REQ)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    always_comb begin
        sel_roben = req_roben[32'(grant_idx) * ROBEN_W +: ROBEN_W];
        sel_data  = req_data[32'(grant_idx) * DATA_W +: DATA_W];
        zero_tag  = (sel_roben == ROBEN_W'(ROBEN_NONE));
        req_ready = (grant_any && !flush) ? grant : '0;

        ptr_d   = ptr_q;
        valid_d = 1'b0;
        roben_d = roben_q;
        data_d  = data_q;
        src_d   = src_q;
        err_d   = err_q;

        if (flush) begin
            ptr_d = '0;
        end else if (grant_any) begin
            ptr_d = SRC_W'(rr_next(32'(grant_idx), N_REQ));
            // Null-tag results are consumed but never reach the bus.
            if (zero_tag) begin
                err_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                roben_d = sel_roben;
                data_d  = sel_data;
                src_d   = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            valid_q <= 1'b0;
            roben_q <= '0;
            data_q  <= '0;
            src_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            roben_q <= roben_d;
            data_q  <= data_d;
            src_q   <= src_d;
            err_q   <= err_d;
        end
    end

    assign cdb_valid    = valid_q;
    assign cdb_roben    = roben_q;
    assign cdb_data     = data_q;
    assign cdb_src      = src_q;
    assign err_zero_tag = err_q;

endmodule
